// File: rtl/text_buffer.sv
// Character-cell text buffer: cursor-addressed writes, scroll and clear sweeps, combinational read.
// Optional blinking cursor overlay is enabled by defining TEXT_BUFFER_CURSOR_EN.
module text_buffer #(
  parameter int unsigned ROW_NUMBER = 7,
  parameter int unsigned COL_NUMBER = 20,
  parameter logic [7:0]  BLANK_ID   = 8'h20,
  parameter logic [7:0]  CURSOR_ID  = 8'h7F,
  parameter int unsigned BLINK_BITS = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_data,
  input  logic [3:0] char_row,
  input  logic [5:0] char_col,
  output logic [7:0] character_id,
  output logic [3:0] cursor_row,
  output logic [5:0] cursor_col
);
  localparam int unsigned Cells     = ROW_NUMBER * COL_NUMBER;
  localparam int unsigned IdxW      = $clog2(Cells);
  localparam logic [3:0]  LastRow   = 4'(ROW_NUMBER - 1);
  localparam logic [5:0]  LastCol   = 6'(COL_NUMBER - 1);
  localparam logic [7:0]  LastCell  = 8'(Cells - 1);
  localparam logic [7:0]  CopyCells = 8'(Cells - COL_NUMBER);

  typedef enum logic [1:0] {StClear, StIdle, StScroll} state_e;

  state_e          state_q;
  logic [7:0]      sweep_q;
  logic [3:0]      cur_row_q;
  logic [5:0]      cur_col_q;
  logic            ready_q;
  logic [7:0]      mem [Cells];

  logic            accept, is_print, is_newline, is_bs, is_clear;
  logic [3:0]      bs_row;
  logic [5:0]      bs_col;
  logic            mem_we;
  logic [IdxW-1:0] mem_waddr;
  logic [7:0]      mem_wdata;

  function automatic logic [IdxW-1:0] cell_idx(input logic [3:0] r, input logic [5:0] c);
    return IdxW'(32'(r) * COL_NUMBER + 32'(c));
  endfunction

  assign accept     = wr_valid && ready_q;
  assign is_print   = (wr_data >= 8'h20) && (wr_data <= 8'h7E);
  assign is_newline = (wr_data == 8'h0A) || (wr_data == 8'h0D);
  assign is_bs      = (wr_data == 8'h08);
  assign is_clear   = (wr_data == 8'h0C);

  assign wr_ready   = ready_q;
  assign cursor_row = cur_row_q;
  assign cursor_col = cur_col_q;

  always_comb begin
    bs_row = cur_row_q;
    bs_col = cur_col_q;
    if (cur_col_q != 6'd0) begin
      bs_col = cur_col_q - 6'd1;
    end else if (cur_row_q != 4'd0) begin
      bs_row = cur_row_q - 4'd1;
      bs_col = LastCol;
    end
  end

  // Cell write port: sweeps own it while busy, accepted codes own it in idle.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = IdxW'(sweep_q);
    mem_wdata = BLANK_ID;
    case (state_q)
      StClear: mem_we = 1'b1;
      StScroll: begin
        mem_we = 1'b1;
        if (sweep_q < CopyCells) begin
          mem_wdata = mem[IdxW'(32'(sweep_q) + COL_NUMBER)];
        end
      end
      StIdle: begin
        if (accept && is_print) begin
          mem_we    = 1'b1;
          mem_waddr = cell_idx(cur_row_q, cur_col_q);
          mem_wdata = wr_data;
        end else if (accept && is_bs) begin
          mem_we    = 1'b1;
          mem_waddr = cell_idx(bs_row, bs_col);
        end
      end
      default: mem_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StClear;
      sweep_q   <= '0;
      cur_row_q <= '0;
      cur_col_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        StClear, StScroll: begin
          if (state_q == StClear) begin
            cur_row_q <= '0;
            cur_col_q <= '0;
          end
          if (sweep_q == LastCell) begin
            sweep_q <= '0;
            state_q <= StIdle;
            ready_q <= 1'b1;
          end else begin
            sweep_q <= sweep_q + 8'd1;
          end
        end
        StIdle: begin
          if (accept) begin
            if (is_clear) begin
              state_q   <= StClear;
              ready_q   <= 1'b0;
              cur_row_q <= '0;
              cur_col_q <= '0;
            end else if (is_bs) begin
              cur_row_q <= bs_row;
              cur_col_q <= bs_col;
            end else if (is_newline || (is_print && cur_col_q == LastCol)) begin
              cur_col_q <= '0;
              if (cur_row_q == LastRow) begin
                state_q <= StScroll;
                ready_q <= 1'b0;
              end else begin
                cur_row_q <= cur_row_q + 4'd1;
              end
            end else if (is_print) begin
              cur_col_q <= cur_col_q + 6'd1;
            end
          end
        end
        default: begin
          state_q <= StClear;
          sweep_q <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef TEXT_BUFFER_CURSOR_EN
  logic [BLINK_BITS-1:0] blink_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_q <= '0;
    end else begin
      blink_q <= blink_q + 1'b1;
    end
  end
`endif

  always_comb begin
    character_id = BLANK_ID;
    if (char_row <= LastRow && char_col <= LastCol) begin
      character_id = mem[cell_idx(char_row, char_col)];
    end
`ifdef TEXT_BUFFER_CURSOR_EN
    if (state_q == StIdle && blink_q[BLINK_BITS-1] &&
        char_row == cur_row_q && char_col == cur_col_q) begin
      character_id = CURSOR_ID;
    end
`endif
  end

endmodule

// File: tb/tb_text_buffer.sv
// Bench for text_buffer: directed steps plus random codes checked against a linear-position
// array model of the screen.
module tb_text_buffer;
  localparam int ROWS = 7;
  localparam int COLS = 20;
  localparam int N    = ROWS * COLS;
`ifdef TEXT_BUFFER_CURSOR_EN
  localparam int BLINK = 4;
`else
  localparam int BLINK = 24;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [3:0] char_row = 4'd0;
  logic [5:0] char_col = 6'd0;
  logic       wr_ready;
  logic [7:0] character_id;
  logic [3:0] cursor_row;
  logic [5:0] cursor_col;

  int checks = 0;
  int errors = 0;

  logic [7:0] model [N];
  int pos;

  always #5 clk = ~clk;

  text_buffer #(
    .ROW_NUMBER(ROWS),
    .COL_NUMBER(COLS),
    .BLANK_ID  (8'h20),
    .CURSOR_ID (8'h7F),
    .BLINK_BITS(BLINK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .char_row    (char_row),
    .char_col    (char_col),
    .character_id(character_id),
    .cursor_row  (cursor_row),
    .cursor_col  (cursor_col)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) model[i] = 8'h20;
    pos = 0;
  endtask

  task automatic model_scroll();
    for (int i = 0; i < N - COLS; i++) model[i] = model[i + COLS];
    for (int i = N - COLS; i < N; i++) model[i] = 8'h20;
    pos = N - COLS;
  endtask

  task automatic model_apply(input logic [7:0] d, output bit busy);
    busy = 1'b0;
    if (d >= 8'h20 && d <= 8'h7E) begin
      model[pos] = d;
      pos++;
      if (pos == N) begin model_scroll(); busy = 1'b1; end
    end else if (d == 8'h0A || d == 8'h0D) begin
      pos = (pos / COLS + 1) * COLS;
      if (pos == N) begin model_scroll(); busy = 1'b1; end
    end else if (d == 8'h08) begin
      if (pos > 0) pos--;
      model[pos] = 8'h20;
    end else if (d == 8'h0C) begin
      model_clear();
      busy = 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = d;
    chk("ready_before_write", wr_ready, 1);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  // Hammers wr_valid with junk while busy; those codes must be ignored.
  task automatic wait_ready(input string tag, input int exp);
    int n = 0;
    wr_valid = 1'b1;
    while (wr_ready !== 1'b1 && n < 1000) begin
      wr_data = 8'($urandom_range(32, 126));
      @(posedge clk);
      #1;
      n++;
    end
    wr_valid = 1'b0;
    chk(tag, n, exp);
  endtask

  task automatic check_cursor(input string tag);
    chk({tag, "_row"}, cursor_row, pos / COLS);
    chk({tag, "_col"}, cursor_col, pos % COLS);
  endtask

  task automatic read_cell(input int r, input int c, output logic [7:0] v);
    char_row = 4'(r);
    char_col = 6'(c);
    #1;
    v = character_id;
  endtask

  task automatic check_all(input string tag);
    logic [7:0] v;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
`ifdef TEXT_BUFFER_CURSOR_EN
        if (r * COLS + c == pos) continue;
`endif
        read_cell(r, c, v);
        chk(tag, v, model[r * COLS + c]);
      end
    end
  endtask

  task automatic do_op(input logic [7:0] d);
    bit busy;
    send(d);
    model_apply(d, busy);
    if (busy) wait_ready("busy_len", N);
    else chk("ready_after_op", wr_ready, 1);
    check_cursor("cursor");
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] d;
    bit busy;
    int k;
    int hits;

    // Reset state
    #1;
    chk("reset_ready", wr_ready, 0);
    chk("reset_row", cursor_row, 0);
    chk("reset_col", cursor_col, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ready("reset_clear_len", N);
    model_clear();
    check_all("cell_after_reset");
    check_cursor("cursor_after_reset");

    // Back-to-back writes
    do_op(8'h41);
    do_op(8'h42);
    read_cell(0, 0, v); chk("cell_0_0", v, 8'h41);
    read_cell(0, 1, v); chk("cell_0_1", v, 8'h42);
    chk("ab_row", cursor_row, 0);
    chk("ab_col", cursor_col, 2);

    // Fill row 0 to wrap to (1,0), then backspace across the row boundary
    for (int i = 0; i < COLS - 2; i++) do_op(8'h58);
    chk("wrap_row", cursor_row, 1);
    chk("wrap_col", cursor_col, 0);
    do_op(8'h08);
    chk("bs_row", cursor_row, 0);
    chk("bs_col", cursor_col, 19);
    read_cell(0, 19, v); chk("bs_cell_0_19", v, 8'h20);
    read_cell(0, 18, v); chk("bs_cell_0_18", v, 8'h58);

    // Clear, then backspace at home does nothing
    do_op(8'h0C);
    check_all("cell_after_clear");
    do_op(8'h08);
    chk("bs_home_row", cursor_row, 0);
    chk("bs_home_col", cursor_col, 0);

    // Fill whole screen to force a scroll
    do_op(8'h0C);
    for (int i = 0; i < N; i++) do_op(8'h41);
    read_cell(5, 0, v); chk("scroll_cell_5_0", v, 8'h41);
    read_cell(6, 7, v); chk("scroll_cell_6_7", v, 8'h20);
    chk("scroll_row", cursor_row, 6);
    chk("scroll_col", cursor_col, 0);
    check_all("cell_after_scroll");
    do_op(8'h42);
    read_cell(6, 0, v); chk("after_scroll_b", v, 8'h42);

    // Out-of-range reads
    read_cell(7, 0, v);   chk("oor_row7", v, 8'h20);
    read_cell(0, 20, v);  chk("oor_col20", v, 8'h20);
    read_cell(15, 63, v); chk("oor_max", v, 8'h20);

`ifdef TEXT_BUFFER_CURSOR_EN
    hits = 0;
    char_row = cursor_row;
    char_col = cursor_col;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (character_id == 8'h7F) hits++;
    end
    chk("blink_duty", hits, 8);
`endif

    // Random codes against the model
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 99);
      if (k < 70) d = 8'($urandom_range(32, 126));
      else if (k < 80) d = (k < 75) ? 8'h0A : 8'h0D;
      else if (k < 90) d = (pos == 0) ? 8'h41 : 8'h08;
      else if (k < 92) d = 8'h0C;
      else begin
        d = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(127, 255)) : 8'($urandom_range(0, 31));
        if (d == 8'h08 || d == 8'h0A || d == 8'h0C || d == 8'h0D) d = 8'h1B;
      end
      do_op(d);
      k = $urandom_range(0, N - 1);
`ifdef TEXT_BUFFER_CURSOR_EN
      if (k == pos) k = (k + 1) % N;
`endif
      read_cell(k / COLS, k % COLS, v);
      chk("rand_cell", v, model[k]);
      if (i % 50 == 49) check_all("rand_all");
    end

    // Reset in the middle of a scroll
    busy = 1'b0;
    k = 0;
    while (!busy && k < 20) begin
      send(8'h0A);
      model_apply(8'h0A, busy);
      k++;
    end
    chk("scroll_started", wr_ready, 0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_ready", wr_ready, 0);
    chk("midreset_row", cursor_row, 0);
    chk("midreset_col", cursor_col, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    wait_ready("midreset_clear_len", N);
    check_all("cell_after_midreset");
    check_cursor("cursor_after_midreset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_buffer.md
TEXT_BUFFER -- requirements
Module: text_buffer

Interface
REQ-001 SHALL have parameter ROW_NUMBER, default 7, text rows held.
REQ-002 SHALL have parameter COL_NUMBER, default 20, characters per row.
REQ-003 SHALL have parameter BLANK_ID, default 8'h20, id written to empty cells.
REQ-004 SHALL have parameter CURSOR_ID, default 8'h7F, id shown at cursor (REQ-027 only).
REQ-005 SHALL have parameter BLINK_BITS, default 24, blink counter width (REQ-027 only).
REQ-006 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port wr_valid  input  1  wr_data holds a character/control code.
REQ-009 SHALL have port wr_ready  output  1  block can accept a code this cycle.
REQ-010 SHALL have port wr_data  input  8  character id or control code.
REQ-011 SHALL have port char_row  input  4  display read row from the pixel encoder.
REQ-012 SHALL have port char_col  input  6  display read column from the pixel encoder.
REQ-013 SHALL have port character_id  output  8  id stored at (char_row, char_col).
REQ-014 SHALL have ports cursor_row  output  4  and cursor_col  output  6  current write position.

Function
REQ-015 SHALL store ROW_NUMBER x COL_NUMBER 8-bit cells; character_id combinational from cells, BLANK_ID when char_row>=ROW_NUMBER or char_col>=COL_NUMBER.
REQ-016 SHALL accept a code only on a cycle with wr_valid && wr_ready; wr_data ignored otherwise.
REQ-017 SHALL use FSM states CLEAR, IDLE, SCROLL; wr_ready=1 only in IDLE.
REQ-018 Printable (8'h20..8'h7E) accepted at edge N: cell(cursor) <= wr_data and cursor advances at edge N; col COL_NUMBER-1 wraps to col 0, row+1.
REQ-019 8'h0A or 8'h0D: cursor col <= 0, row+1; no cell written.
REQ-020 Row advance from row ROW_NUMBER-1 SHALL enter SCROLL at edge N with cursor <= (ROW_NUMBER-1, 0).
REQ-021 SCROLL SHALL copy one cell per cycle, row r+1 to row r for r=0..ROW_NUMBER-2, then write BLANK_ID to each cell of last row, one per cycle: ROW_NUMBER*COL_NUMBER cycles (140 default), then IDLE.
REQ-022 8'h08 (backspace): if col>0, col-1; elif row>0, row-1 and col COL_NUMBER-1; at (0,0) no change; cell at new cursor <= BLANK_ID; stays IDLE.
REQ-023 8'h0C SHALL enter CLEAR: one cell per cycle set to BLANK_ID, 140 cycles default, cursor <= (0,0), then IDLE.
REQ-024 All other codes SHALL be accepted and discarded with no state change.
REQ-025 Cell/counter arithmetic SHALL never address beyond ROW_NUMBER x COL_NUMBER; sweep counter 8 bits.

Reset
REQ-026 rst_n low SHALL immediately set cursor (0,0), sweep counter 0, wr_ready 0, state CLEAR, blink counter 0; on release the CLEAR sweep runs (140 cycles) then IDLE; cells not reset directly; rst_n asserted mid-SCROLL or mid-CLEAR aborts the sweep and restarts CLEAR.

Configuration
REQ-027 With TEXT_BUFFER_CURSOR_EN defined, a free-running BLINK_BITS counter SHALL make character_id = CURSOR_ID when (char_row,char_col)==cursor and counter MSB=1 in IDLE; without it, no counter exists and character_id always reflects stored cells.

Verification
REQ-028 Release reset, hold wr_valid -> wr_ready low exactly 140 cycles, then every cell reads 8'h20, cursor (0,0).
REQ-029 Write 8'h41,8'h42 back-to-back -> both accepted consecutive cycles; cell(0,0)=8'h41, cell(0,1)=8'h42, cursor (0,2).
REQ-030 Write 140 'A' then 'B' -> after 140th, wr_ready low 140 cycles; cell(5,0)=8'h41, row 6 all 8'h20, cursor (6,0); 'B' then at (6,0).
REQ-031 At (1,0) write 8'h08 -> cursor (0,19), cell(0,19)=8'h20; at (0,0) write 8'h08 -> cursor stays (0,0).
REQ-032 Mid-SCROLL drop rst_n for 1 cycle -> cursor (0,0), full CLEAR runs, all cells 8'h20.
REQ-033 Read char_row=7 or char_col=20 -> character_id 8'h20; with TEXT_BUFFER_CURSOR_EN, BLINK_BITS=4, read cursor cell -> 8'h7F for 8 cycles, stored id for 8.
